// File: rtl/aes_engine_ctrl_pkg.sv
// Shared types for the AES engine controller: engine control/flag records and FSM states.
package aes_engine_ctrl_pkg;

    localparam int AES_BLOCK_WORDS = 4;

    typedef struct packed {
        logic [1:0]   request_counter;
        logic         core_encode_decode;
        logic         core_init_key;
        logic         core_start;
        logic [255:0] core_key;
        logic         core_key_mode;
        logic         data_out_valid;
        logic         clear;
    } ctrl_engine_t;

    typedef struct packed {
        logic core_ready;
        logic core_done;
    } flags_engine_t;

    typedef enum logic [3:0] {
        IDLE,
        KEY_INIT,
        KEY_WAIT,
        LOAD,
        SETTLE,
        START,
        WAIT_CORE,
        CAPTURE,
        DRAIN,
        DONE
    } aes_ctrl_state_e;

endpackage

// File: rtl/aes_engine_ctrl_if.sv
// Controller <-> datapath engine / streamer signals.
interface aes_engine_ctrl_if;
    import aes_engine_ctrl_pkg::*;

    ctrl_engine_t  ctrl;
    flags_engine_t flags;
    logic          in_hs;
    logic          out_ready;

    modport master (output ctrl, input flags, input in_hs, input out_ready);
    modport slave  (input ctrl, output flags, output in_hs, output out_ready);

endinterface

// File: rtl/aes_engine_ctrl.sv
// Job sequencer for the AES datapath: key expansion, then per block load/start/capture/drain.
//
// state     | meaning
// IDLE      | waiting for start_i
// KEY_INIT  | pulse core_init_key once the core is ready
// KEY_WAIT  | key expansion in progress
// LOAD      | accept 4 input words
// SETTLE    | engine moves its input buffer into core_input
// START     | pulse core_start once the core is ready
// WAIT_CORE | block in flight, guarded by the timeout
// CAPTURE   | engine latches the result
// DRAIN     | present 4 output words
// DONE      | job-complete pulse
module aes_engine_ctrl
    import aes_engine_ctrl_pkg::*;
#(
    parameter int NB_W        = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 clear_i,
    input  logic [255:0]         cfg_key_i,
    input  logic                 cfg_key_mode_i,
    input  logic                 cfg_encdec_i,
    input  logic [NB_W-1:0]      cfg_num_blocks_i,
    aes_engine_ctrl_if.master    eng,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [NB_W-1:0]      blocks_done_o
);

    localparam int         TW     = $clog2(TIMEOUT_CYC);
    localparam logic [1:0] LAST_W = 2'(AES_BLOCK_WORDS - 1);

    aes_ctrl_state_e state_q, state_d;
    ctrl_engine_t    ctrl_d;
    logic [1:0]      w_q;
    logic [NB_W-1:0] blk_q, nblk_q;
    logic [255:0]    key_q;
    logic            mode_q, encdec_q;
    logic [TW-1:0]   tmo_q;
    logic            err_q, abort_q, done_q, skip_q;
    logic            start_acc, last_in, last_out, tmo_hit;

    assign start_acc = (state_q == IDLE) && start_i && !clear_i;
    assign last_in   = (state_q == LOAD) && eng.in_hs && (w_q == LAST_W);
    assign last_out  = (state_q == DRAIN) && eng.out_ready && (w_q == LAST_W);
    assign tmo_hit   = (state_q == WAIT_CORE) && !eng.flags.core_done && (tmo_q == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:      if (start_i) state_d = (cfg_num_blocks_i == '0) ? DONE : KEY_INIT;
                KEY_INIT:  if (eng.flags.core_ready) state_d = KEY_WAIT;
                // ready is still stale in the first KEY_WAIT cycle
                KEY_WAIT:  if (!skip_q && eng.flags.core_ready) state_d = LOAD;
                LOAD:      if (last_in) state_d = SETTLE;
                SETTLE:    state_d = START;
                START:     if (eng.flags.core_ready) state_d = WAIT_CORE;
                WAIT_CORE: begin
                    if (eng.flags.core_done) state_d = CAPTURE;
                    else if (tmo_hit)        state_d = IDLE;
                end
                CAPTURE:   state_d = DRAIN;
                DRAIN:     if (last_out) state_d = ((blk_q + NB_W'(1)) == nblk_q) ? DONE : LOAD;
                DONE:      state_d = IDLE;
                default:   state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        ctrl_d                    = '0;
        ctrl_d.core_key           = key_q;
        ctrl_d.core_key_mode      = mode_q;
        ctrl_d.core_encode_decode = encdec_q;
        ctrl_d.clear              = (state_q == DONE) || abort_q;
        unique case (state_q)
            KEY_INIT: ctrl_d.core_init_key = eng.flags.core_ready && !clear_i;
            LOAD:     ctrl_d.request_counter = w_q;
            START:    ctrl_d.core_start = eng.flags.core_ready && !clear_i;
            DRAIN: begin
                ctrl_d.request_counter = w_q;
                ctrl_d.data_out_valid  = !clear_i;
            end
            default: ;
        endcase
    end

    assign eng.ctrl      = ctrl_d;
    assign busy_o        = (state_q != IDLE);
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign blocks_done_o = blk_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_q      <= '0;
            blk_q    <= '0;
            nblk_q   <= '0;
            key_q    <= '0;
            mode_q   <= 1'b0;
            encdec_q <= 1'b0;
            tmo_q    <= '0;
            err_q    <= 1'b0;
            abort_q  <= 1'b0;
            done_q   <= 1'b0;
            skip_q   <= 1'b0;
        end else begin
            abort_q <= clear_i || tmo_hit;
            done_q  <= (state_q == DONE) && !clear_i;
            skip_q  <= (state_q == KEY_INIT);
            if (clear_i) begin
                w_q   <= '0;
                blk_q <= '0;
                err_q <= 1'b0;
            end else begin
                if (start_acc) begin
                    key_q    <= cfg_key_i;
                    mode_q   <= cfg_key_mode_i;
                    encdec_q <= cfg_encdec_i;
                    nblk_q   <= cfg_num_blocks_i;
                    blk_q    <= '0;
                    w_q      <= '0;
                    err_q    <= 1'b0;
                end
                // the 2-bit word index wraps from 3 to 0 on its own
                if (((state_q == LOAD) && eng.in_hs) || ((state_q == DRAIN) && eng.out_ready))
                    w_q <= w_q + 2'd1;
                if (last_out) blk_q <= blk_q + NB_W'(1);
                if (state_q == START)
                    tmo_q <= TW'(TIMEOUT_CYC - 1);
                else if ((state_q == WAIT_CORE) && (tmo_q != '0))
                    tmo_q <= tmo_q - TW'(1);
                if (tmo_hit) err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aes_engine_ctrl.sv
// Directed bench for aes_engine_ctrl with a behavioural stand-in for the AES core.
module tb_aes_engine_ctrl;
    import aes_engine_ctrl_pkg::*;

    localparam int NB_W = 16;
    localparam logic [255:0] K128 = {128'h0, 128'h000102030405060708090a0b0c0d0e0f};
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic clk = 1'b0;
    logic rst_n;
    logic start, clear;
    logic [255:0] key;
    logic kmode, encdec;
    logic [NB_W-1:0] nb;
    logic busy, done, err;
    logic [NB_W-1:0] blk;

    aes_engine_ctrl_if eng();

    aes_engine_ctrl #(.NB_W(NB_W), .TIMEOUT_CYC(16)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .clear_i(clear),
        .cfg_key_i(key), .cfg_key_mode_i(kmode), .cfg_encdec_i(encdec),
        .cfg_num_blocks_i(nb), .eng(eng), .busy_o(busy), .done_o(done),
        .err_o(err), .blocks_done_o(blk)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0;
    int n_init = 0, n_start = 0, n_done = 0, n_busy = 0, pulse_viol = 0;
    int start_cyc = 0, last_load_cyc = 0;
    logic prev_init = 1'b0, prev_start = 1'b0;
    logic [31:0] drained[$];
    logic [7:0] gap_pat = 8'hff;
    logic tie_low = 1'b0;
    logic res_mode = 1'b0;
    logic eng_kind = 1'b0;
    int eng_cnt = 0;

    // FIPS-197 C.1 (AES-128) and C.3 (AES-256) ciphertexts, word 0 = least significant
    function automatic logic [31:0] res_word(input logic m, input logic [1:0] i);
        case ({m, i})
            3'b000:  return 32'h70b4c55a;
            3'b001:  return 32'hd8cdb780;
            3'b010:  return 32'h6a7b0430;
            3'b011:  return 32'h69c4e0d8;
            3'b100:  return 32'h4b496089;
            3'b101:  return 32'heafc4990;
            3'b110:  return 32'h516745bf;
            default: return 32'h8ea2b7ca;
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        eng.in_hs = gap_pat[cyc[2:0]];
    end

    // core stand-in: drops ready after init/start, returns it (plus done) a few cycles later
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng.flags <= 2'b10;
            eng_cnt   <= 0;
            eng_kind  <= 1'b0;
            res_mode  <= 1'b0;
        end else begin
            eng.flags.core_done <= 1'b0;
            if (eng.ctrl.clear) begin
                eng_cnt <= 0;
                eng.flags.core_ready <= 1'b1;
            end else if (eng.ctrl.core_init_key) begin
                eng.flags.core_ready <= 1'b0;
                eng_cnt  <= 3;
                eng_kind <= 1'b0;
            end else if (eng.ctrl.core_start) begin
                eng.flags.core_ready <= 1'b0;
                eng_cnt  <= 4;
                eng_kind <= 1'b1;
                res_mode <= eng.ctrl.core_key_mode;
            end else if (eng_cnt > 0) begin
                eng_cnt <= eng_cnt - 1;
                if (eng_cnt == 1) begin
                    eng.flags.core_ready <= 1'b1;
                    if (eng_kind && !tie_low) eng.flags.core_done <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (eng.ctrl.core_init_key) n_init++;
        if (eng.ctrl.core_start) begin
            n_start++;
            start_cyc = cyc;
        end
        if ((eng.ctrl.core_init_key && prev_init) || (eng.ctrl.core_start && prev_start)) pulse_viol++;
        prev_init  = eng.ctrl.core_init_key;
        prev_start = eng.ctrl.core_start;
        if (done) n_done++;
        if (busy) n_busy++;
        if (eng.ctrl.data_out_valid && eng.out_ready)
            drained.push_back(res_word(res_mode, eng.ctrl.request_counter));
        if (!eng.ctrl.data_out_valid && eng.ctrl.request_counter == 2'd3 && eng.in_hs)
            last_load_cyc = cyc;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [255:0] k, input logic m, input logic ed, input int n);
        step();
        key = k; kmode = m; encdec = ed; nb = NB_W'(n); start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; clear = 1'b0; key = '0; kmode = 1'b0;
        encdec = 1'b0; nb = '0; eng.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (eng.ctrl !== '0) begin
            failures++; $display("FAIL reset_ctrl: got %h expected 0", eng.ctrl);
        end
        checks++;
        if ({busy, done, err, blk} !== '0) begin
            failures++; $display("FAIL reset_outputs: busy=%b done=%b err=%b blk=%0d expected all 0", busy, done, err, blk);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || eng.ctrl.request_counter !== 2'd0) begin
            failures++; $display("FAIL post_reset_idle: busy=%b rc=%0d expected 0 0", busy, eng.ctrl.request_counter);
        end
    endtask

    task automatic test_aes128_single();
        int i0, s0, d0, b, bad;
        bit ok;
        i0 = n_init; s0 = n_start; d0 = n_done; b = drained.size();
        gap_pat = 8'hff; eng.out_ready = 1'b1;
        pulse_start(K128, 1'b0, 1'b1, 1);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL a128_busy: got %b expected 1", busy); end
        checks++;
        if ({eng.ctrl.core_key, eng.ctrl.core_key_mode, eng.ctrl.core_encode_decode} !== {K128, 1'b0, 1'b1}) begin
            failures++; $display("FAIL a128_cfg: key=%h mode=%b ed=%b", eng.ctrl.core_key, eng.ctrl.core_key_mode, eng.ctrl.core_encode_decode);
        end
        wait_done(300, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL a128_done_timeout: no done_o within 300 cycles expected done"); end
        step();
        checks++;
        if (n_init - i0 != 1 || n_start - s0 != 1) begin
            failures++; $display("FAIL a128_pulses: init=%0d start=%0d expected 1 1", n_init - i0, n_start - s0);
        end
        checks++;
        if (start_cyc - last_load_cyc != 2) begin
            failures++; $display("FAIL a128_start_latency: got %0d cycles after last load word expected 2", start_cyc - last_load_cyc);
        end
        bad = 0;
        if (drained.size() - b != 4) bad++;
        else for (int i = 0; i < 4; i++) if (drained[b + i] !== res_word(1'b0, 2'(i))) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL a128_words: %0d wrong of 4 (count %0d) expected 0", bad, drained.size() - b); end
        checks++;
        if (blk !== 16'd1 || n_done - d0 != 1 || busy !== 1'b0) begin
            failures++; $display("FAIL a128_end: blk=%0d dones=%0d busy=%b expected 1 1 0", blk, n_done - d0, busy);
        end
    endtask

    task automatic test_aes256_three();
        int i0, s0, d0, b, bad, lows, sz;
        bit ok;
        i0 = n_init; s0 = n_start; d0 = n_done; b = drained.size();
        gap_pat = 8'b1011_0101; eng.out_ready = 1'b1;
        pulse_start(K256, 1'b1, 1'b1, 3);
        for (int i = 0; i < 400 && drained.size() - b < 6; i++) step();
        checks++;
        if (drained.size() - b != 6) begin failures++; $display("FAIL a256_reach_stall: got %0d words expected 6", drained.size() - b); end
        eng.out_ready = 1'b0;
        lows = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (eng.ctrl.data_out_valid !== 1'b1) lows++;
            step();
        end
        sz = drained.size() - b;
        eng.out_ready = 1'b1;
        checks++;
        if (lows != 0 || sz != 6) begin
            failures++; $display("FAIL a256_stall: valid low %0d cycles, words %0d expected 0 6", lows, sz);
        end
        wait_done(600, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL a256_done_timeout: no done_o within 600 cycles expected done"); end
        step();
        bad = 0;
        if (drained.size() - b != 12) bad++;
        else for (int i = 0; i < 12; i++) if (drained[b + i] !== res_word(1'b1, 2'(i % 4))) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL a256_words: %0d wrong of 12 (count %0d) expected 0", bad, drained.size() - b); end
        checks++;
        if (blk !== 16'd3 || n_done - d0 != 1 || n_init - i0 != 1 || n_start - s0 != 3) begin
            failures++; $display("FAIL a256_end: blk=%0d done=%0d init=%0d start=%0d expected 3 1 1 3", blk, n_done - d0, n_init - i0, n_start - s0);
        end
    endtask

    task automatic test_zero_blocks();
        int i0, s0, d0, bz;
        i0 = n_init; s0 = n_start; d0 = n_done; bz = n_busy;
        pulse_start(K128, 1'b0, 1'b1, 0);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || eng.ctrl.clear !== 1'b1) begin
            failures++; $display("FAIL zero_cycle1: busy=%b done=%b clear=%b expected 1 0 1", busy, done, eng.ctrl.clear);
        end
        step();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL zero_cycle2: done=%b busy=%b expected 1 0", done, busy);
        end
        step();
        step();
        checks++;
        if (n_busy - bz != 1 || n_done - d0 != 1 || n_init - i0 != 0 || n_start - s0 != 0 || blk !== 16'd0) begin
            failures++; $display("FAIL zero_counts: busy=%0d done=%0d init=%0d start=%0d blk=%0d expected 1 1 0 0 0",
                                 n_busy - bz, n_done - d0, n_init - i0, n_start - s0, blk);
        end
    endtask

    task automatic test_timeout();
        int ecyc;
        bit ok;
        tie_low = 1'b1; gap_pat = 8'hff; ecyc = 0; ok = 1'b0;
        pulse_start(K128, 1'b0, 1'b1, 1);
        for (int i = 0; i < 200; i++) begin
            step();
            if (err === 1'b1) begin ok = 1'b1; ecyc = cyc; break; end
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL tmo_no_err: err_o never set expected 1"); end
        checks++;
        if (ecyc - start_cyc != 17) begin failures++; $display("FAIL tmo_latency: err %0d cycles after core_start expected 17", ecyc - start_cyc); end
        checks++;
        if (eng.ctrl.clear !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL tmo_abort: clear=%b busy=%b expected 1 0", eng.ctrl.clear, busy);
        end
        step();
        checks++;
        if (eng.ctrl.clear !== 1'b0 || err !== 1'b1) begin
            failures++; $display("FAIL tmo_sticky: clear=%b err=%b expected 0 1", eng.ctrl.clear, err);
        end
        tie_low = 1'b0;
        pulse_start(K128, 1'b0, 1'b1, 0);
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL tmo_err_cleared: got %b expected 0", err); end
        wait_done(20, ok);
        step();
    endtask

    task automatic test_clear_in_drain();
        int b;
        b = drained.size();
        gap_pat = 8'hff; eng.out_ready = 1'b1;
        pulse_start(K128, 1'b0, 1'b1, 2);
        for (int i = 0; i < 400 && drained.size() - b < 6; i++) step();
        checks++;
        if (blk !== 16'd1 || eng.ctrl.request_counter !== 2'd2) begin
            failures++; $display("FAIL clr_setup: blk=%0d rc=%0d expected 1 2", blk, eng.ctrl.request_counter);
        end
        clear = 1'b1; start = 1'b1; key = K256; kmode = 1'b1; nb = 16'd5;
        @(negedge clk);
        checks++;
        if (eng.ctrl.data_out_valid !== 1'b0) begin failures++; $display("FAIL clr_valid_forced: got %b expected 0", eng.ctrl.data_out_valid); end
        step();
        clear = 1'b0; start = 1'b0;
        checks++;
        if (busy !== 1'b0 || blk !== 16'd0 || eng.ctrl.data_out_valid !== 1'b0 || eng.ctrl.clear !== 1'b1) begin
            failures++; $display("FAIL clr_next: busy=%b blk=%0d valid=%b clear=%b expected 0 0 0 1",
                                 busy, blk, eng.ctrl.data_out_valid, eng.ctrl.clear);
        end
        checks++;
        if (eng.ctrl.core_key !== K128 || eng.ctrl.core_key_mode !== 1'b0) begin
            failures++; $display("FAIL clr_start_ignored: key=%h mode=%b", eng.ctrl.core_key, eng.ctrl.core_key_mode);
        end
        step();
        checks++;
        if (busy !== 1'b0 || drained.size() - b != 6) begin
            failures++; $display("FAIL clr_idle: busy=%b words=%0d expected 0 6", busy, drained.size() - b);
        end
    endtask

    task automatic test_restart_busy();
        int s0, d0, b, bad;
        bit ok;
        s0 = n_start; d0 = n_done; b = drained.size();
        gap_pat = 8'b1101_1011; eng.out_ready = 1'b1;
        pulse_start(K128, 1'b0, 1'b1, 2);
        repeat (5) step();
        key = K256; kmode = 1'b1; encdec = 1'b0; nb = 16'd1; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({eng.ctrl.core_key, eng.ctrl.core_key_mode, eng.ctrl.core_encode_decode} !== {K128, 1'b0, 1'b1} || busy !== 1'b1) begin
            failures++; $display("FAIL restart_cfg: key=%h mode=%b ed=%b busy=%b",
                                 eng.ctrl.core_key, eng.ctrl.core_key_mode, eng.ctrl.core_encode_decode, busy);
        end
        wait_done(600, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL restart_done_timeout: no done_o within 600 cycles expected done"); end
        step();
        bad = 0;
        if (drained.size() - b != 8) bad++;
        else for (int i = 0; i < 8; i++) if (drained[b + i] !== res_word(1'b0, 2'(i % 4))) bad++;
        checks++;
        if (bad != 0 || blk !== 16'd2 || n_done - d0 != 1 || n_start - s0 != 2) begin
            failures++; $display("FAIL restart_end: bad=%0d blk=%0d done=%0d start=%0d expected 0 2 1 2",
                                 bad, blk, n_done - d0, n_start - s0);
        end
        checks++;
        if (pulse_viol != 0) begin failures++; $display("FAIL pulse_rule: %0d back-to-back pulses expected 0", pulse_viol); end
    endtask

    initial begin
        test_reset();
        test_aes128_single();
        test_aes256_three();
        test_zero_blocks();
        test_timeout();
        test_clear_in_drain();
        test_restart_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_engine_ctrl.md
Name: aes_engine_ctrl

Overview:
- Initiator-side control FSM for the AES HWPE datapath engine.
- Drives the engine's control record (ctrl_engine_t) and consumes its flags (flags_engine_t).
- Sequences, per job: key expansion, then for each block: 4-word input load, core start, result capture, 4-word output drain.
- Sits between the register-file job interface (start/clear/config) and the datapath engine, observing the input and output stream handshakes.

Parameters:
- NB_W, 16, width of block-count config and counters.
- TIMEOUT_CYC, 1024, maximum cycles in WAIT_CORE before the error abort.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- start_i  in  1  job trigger pulse; ignored while busy_o=1
- clear_i  in  1  synchronous soft clear
- cfg_key_i  in  256  AES key
- cfg_key_mode_i  in  1  0=AES-128, 1=AES-256
- cfg_encdec_i  in  1  1=encrypt, 0=decrypt
- cfg_num_blocks_i  in  NB_W  number of 128-bit blocks in the job
- in_hs_i  in  1  input-stream handshake (valid & ready) this cycle
- out_ready_i  in  1  output-stream ready from the streamer
- flags_i  in  flags_engine_t  {core_ready, core_done}
- ctrl_o  out  ctrl_engine_t  {request_counter[1:0], core_encode_decode, core_init_key, core_start, core_key[255:0], core_key_mode, data_out_valid, clear}
- busy_o  out  1  job in progress
- done_o  out  1  one-cycle job-complete pulse
- err_o  out  1  sticky core timeout; cleared by start_i or clear_i
- blocks_done_o  out  NB_W  blocks fully drained in the current job

Behaviour:
- Reset: all outputs 0, ctrl_o all fields 0, state IDLE, word and block counters 0.
- Config latch: on accepted start_i, latch key, mode, encdec and num_blocks; ctrl_o key, mode and encdec fields drive the latched copies for the whole job.
- IDLE: request_counter=0.
  - start_i with num_blocks=0 -> DONE.
  - start_i with num_blocks>0 -> KEY_INIT; busy_o=1 from the next cycle.
- KEY_INIT: wait for flags_i.core_ready=1, then assert core_init_key for exactly 1 cycle -> KEY_WAIT.
- KEY_WAIT:
  - Ignore core_ready in the first cycle (core drops ready one cycle after init).
  - Then wait for core_ready=1 -> LOAD.
- LOAD:
  - request_counter = word index w (0..3).
  - Each in_hs_i increments w.
  - The handshake with w=3 -> SETTLE, w wraps to 0.
- SETTLE: 1 cycle. Required because the engine registers its input buffer into core_input one cycle late. -> START.
- START: assert core_start for 1 cycle when core_ready=1 (hold in START otherwise) -> WAIT_CORE; load the timeout counter.
- WAIT_CORE:
  - core_done=1 -> CAPTURE.
  - Timeout counter reaching TIMEOUT_CYC -> err_o=1, clear pulse, -> IDLE.
- CAPTURE: 1 cycle while the engine latches the result -> DRAIN.
- DRAIN:
  - data_out_valid=1, request_counter=w.
  - Each out_ready_i advances w; data_out_valid stays high while out_ready_i=0 (valid must not drop).
  - On the accepted word with w=3: blocks_done_o increments, w wraps to 0.
  - Then -> DONE if blocks_done_o equals num_blocks, else -> LOAD.
- DONE: done_o=1 and ctrl_o.clear=1 for exactly 1 cycle; busy_o=0 from the next cycle -> IDLE. blocks_done_o holds its value until the next start_i.
- clear_i:
  - From any state: -> IDLE next cycle, ctrl_o.clear=1 for that cycle.
  - Counters and err_o zeroed, core_init_key, core_start and data_out_valid forced to 0.
  - clear_i wins over a simultaneous start_i.
- Pulse rule: core_init_key and core_start are never high for 2 consecutive cycles.
- In-flight reset: async reset mid-job returns to reset values immediately; there is no resume.
- Stray handshakes: in_hs_i outside LOAD is ignored; out_ready_i outside DRAIN is ignored.

Decomposition:
- aes_package holds: ctrl_engine_t, flags_engine_t (extended with nothing new), aes_ctrl_state_e (IDLE, KEY_INIT, KEY_WAIT, LOAD, SETTLE, START, WAIT_CORE, CAPTURE, DRAIN, DONE), AES_BLOCK_WORDS=4.
- Single module; no sub-module warranted (the counters are trivial).

Test Plan:
- FIPS-197 AES-128 single block:
  - Stimulus: key 000102…0f, pt words ccddeeff,8899aabb,44556677,00112233.
  - Response: core_init_key pulses once; core_start fires exactly 1 cycle after SETTLE; drained words 70b4c55a,d8cdb780,6a7b0430,69c4e0d8; done_o pulse; blocks_done_o=1.
- Three AES-256 blocks (C.3 vector ×3) with random in_hs_i gaps and out_ready_i stalled 5 cycles mid-drain -> 12 output words in order, data_out_valid held high during the stall, done_o once, blocks_done_o=3.
- num_blocks=0 start -> no init or start pulses; done_o asserts 2 cycles after start_i; busy_o high for 1 cycle.
- core_done tied low, TIMEOUT_CYC=16 -> err_o=1 after 16 cycles in WAIT_CORE, clear pulse, IDLE; the next start_i clears err_o.
- clear_i asserted during DRAIN word 2 together with start_i -> IDLE, blocks_done_o=0, data_out_valid=0 the next cycle, start_i ignored.
- start_i re-pulsed while busy -> no effect on config or counters; job completes with the original config.
